// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  mem_stage_pkg
//  Pipeline record types shared by the memory stage and its neighbours.
//  Revision: 1.0
// ============================================================================
package mem_stage_pkg;

  localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_s;
    logic [31:0] rs2_v;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] u_imm;
    logic        regf_we;
    logic [3:0]  regfilemux_sel;
    logic [5:0]  dest_phys_new;
    logic [5:0]  dest_phys_old;
    logic [4:0]  dest_arch;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic        regf_we;
    logic [3:0]  regfilemux_sel;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] u_imm;
    logic [31:0] mem_rdata;
    logic [5:0]  dest_phys_new;
    logic [5:0]  dest_phys_old;
    logic [4:0]  dest_arch;
  } mem_wb_stage_reg_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  mem_stage
//  EX/MEM register, single-outstanding data-memory handshake and MEM/WB register.
//  Revision: 1.0
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_stage_reg_t ex_mem_in,
  input  logic              flush,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall,
  output logic [31:0]       ex_mem_alu_out_forward,
  output logic              ex_mem_br_en_forward,
  output logic [31:0]       ex_mem_u_imm_forward,
  output logic [4:0]        ex_mem_rd_s,
  output logic              ex_mem_regf_we,
  output mem_wb_stage_reg_t mem_wb
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  ex_mem_stage_reg_t r_ex_mem;
  mem_wb_stage_reg_t r_mem_wb;
  state_t            r_state;
  state_t            w_next_state;

  logic [1:0]  w_off;
  logic [3:0]  w_byte_mask;
  logic        w_aligned;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic [31:0] w_rdata_shift;
  logic [31:0] w_load_data;

  assign w_off      = r_ex_mem.alu_out[1:0];
  assign w_is_load  = (r_ex_mem.opcode == c_OPC_LOAD);
  assign w_is_store = (r_ex_mem.opcode == c_OPC_STORE);

  always_comb begin
    w_byte_mask = 4'b0000;
    w_aligned   = 1'b0;
    case (r_ex_mem.funct3[1:0])
      2'b00: begin
        w_byte_mask = 4'b0001 << w_off;
        w_aligned   = 1'b1;
      end
      2'b01: begin
        w_byte_mask = 4'b0011 << w_off;
        w_aligned   = ~w_off[0];
      end
      2'b10: begin
        w_byte_mask = 4'b1111;
        w_aligned   = (w_off == 2'b00);
      end
      default: begin
        w_byte_mask = 4'b0000;
        w_aligned   = 1'b0;
      end
    endcase
  end

  // Misaligned accesses never reach memory; they retire as a plain pass-through.
  assign w_mem_op = r_ex_mem.valid & (w_is_load | w_is_store) & w_aligned;
  assign stall    = w_mem_op & ~dmem_resp;

  always_comb begin
    w_next_state = r_state;
    dmem_rmask   = 4'b0000;
    dmem_wmask   = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          if (w_is_load) dmem_rmask = w_byte_mask;
          else           dmem_wmask = w_byte_mask;
          if (!dmem_resp) w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_resp || !w_mem_op) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign dmem_addr     = {r_ex_mem.alu_out[31:2], 2'b00};
  assign dmem_wdata    = r_ex_mem.rs2_v << {w_off, 3'b000};
  assign w_rdata_shift = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_data = 32'h0;
    case (r_ex_mem.funct3)
      3'b000:  w_load_data = {{24{w_rdata_shift[7]}}, w_rdata_shift[7:0]};
      3'b001:  w_load_data = {{16{w_rdata_shift[15]}}, w_rdata_shift[15:0]};
      3'b010:  w_load_data = w_rdata_shift;
      3'b100:  w_load_data = {24'h0, w_rdata_shift[7:0]};
      3'b101:  w_load_data = {16'h0, w_rdata_shift[15:0]};
      default: w_load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_mem <= '0;
    end else if (!stall) begin
      r_ex_mem       <= ex_mem_in;
      r_ex_mem.valid <= ex_mem_in.valid & ~flush;
    end
  end

  // While stalled only valid matters downstream; the rest is loaded regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wb <= '0;
    end else begin
      r_mem_wb.valid          <= r_ex_mem.valid & ~stall;
      r_mem_wb.pc             <= r_ex_mem.pc;
      r_mem_wb.inst           <= r_ex_mem.inst;
      r_mem_wb.rd_s           <= r_ex_mem.rd_s;
      r_mem_wb.regf_we        <= r_ex_mem.regf_we;
      r_mem_wb.regfilemux_sel <= r_ex_mem.regfilemux_sel;
      r_mem_wb.alu_out        <= r_ex_mem.alu_out;
      r_mem_wb.br_en          <= r_ex_mem.br_en;
      r_mem_wb.u_imm          <= r_ex_mem.u_imm;
      r_mem_wb.mem_rdata      <= (w_mem_op & w_is_load) ? w_load_data : 32'h0;
      r_mem_wb.dest_phys_new  <= r_ex_mem.dest_phys_new;
      r_mem_wb.dest_phys_old  <= r_ex_mem.dest_phys_old;
      r_mem_wb.dest_arch      <= r_ex_mem.dest_arch;
    end
  end

  assign mem_wb                 = r_mem_wb;
  assign ex_mem_alu_out_forward = r_ex_mem.alu_out;
  assign ex_mem_br_en_forward   = r_ex_mem.br_en;
  assign ex_mem_u_imm_forward   = r_ex_mem.u_imm;
  assign ex_mem_rd_s            = r_ex_mem.rd_s;
  assign ex_mem_regf_we         = r_ex_mem.regf_we & r_ex_mem.valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  tb_mem_stage
//  Randomized bench for mem_stage with a transaction-level reference model.
//  Revision: 1.0
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  ex_mem_stage_reg_t ex_mem_in;
  logic              flush;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              stall;
  logic [31:0]       ex_mem_alu_out_forward;
  logic              ex_mem_br_en_forward;
  logic [31:0]       ex_mem_u_imm_forward;
  logic [4:0]        ex_mem_rd_s;
  logic              ex_mem_regf_we;
  mem_wb_stage_reg_t mem_wb;

  mem_stage dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ex_mem_in              (ex_mem_in),
    .flush                  (flush),
    .dmem_addr              (dmem_addr),
    .dmem_rmask             (dmem_rmask),
    .dmem_wmask             (dmem_wmask),
    .dmem_wdata             (dmem_wdata),
    .dmem_rdata             (dmem_rdata),
    .dmem_resp              (dmem_resp),
    .stall                  (stall),
    .ex_mem_alu_out_forward (ex_mem_alu_out_forward),
    .ex_mem_br_en_forward   (ex_mem_br_en_forward),
    .ex_mem_u_imm_forward   (ex_mem_u_imm_forward),
    .ex_mem_rd_s            (ex_mem_rd_s),
    .ex_mem_regf_we         (ex_mem_regf_we),
    .mem_wb                 (mem_wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ex_mem_stage_reg_t m_held;   // instruction currently sitting in MEM
  int                m_age;    // cycles it has spent there so far
  mem_wb_stage_reg_t m_wb;     // record MEM/WB must show this cycle

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_is_mem(input ex_mem_stage_reg_t h);
    int sz;
    sz = size_bytes(h.funct3);
    if (!h.valid) return 1'b0;
    if (h.opcode != c_OPC_LOAD && h.opcode != c_OPC_STORE) return 1'b0;
    if (sz == 0) return 1'b0;
    return (h.alu_out % sz) == 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] rd, input int off);
    logic [31:0] s, b, h;
    s = rd >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return s;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  int          mm_sz, mm_off, mm_mask;
  bit          mm_mem, mm_exp_stall;
  logic [3:0]  mm_r, mm_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_held = '0;
      m_age  = 0;
      m_wb   = '0;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_rmask", {28'h0, dmem_rmask}, 32'h0);
      chk("rst_wmask", {28'h0, dmem_wmask}, 32'h0);
      chk("rst_wb_valid", {31'h0, mem_wb.valid}, 32'h0);
      chk("rst_fwd_alu", ex_mem_alu_out_forward, 32'h0);
      chk("rst_fwd_we", {31'h0, ex_mem_regf_we}, 32'h0);
    end else begin
      mm_mem       = model_is_mem(m_held);
      mm_sz        = size_bytes(m_held.funct3);
      mm_off       = m_held.alu_out % 4;
      mm_mask      = ((1 << mm_sz) - 1) << mm_off;
      mm_exp_stall = mm_mem && !dmem_resp;
      mm_r = 4'h0;
      mm_w = 4'h0;
      if (mm_mem && m_age == 0) begin
        if (m_held.opcode == c_OPC_LOAD) mm_r = 4'(mm_mask);
        else                             mm_w = 4'(mm_mask);
      end
      chk("stall", {31'h0, stall}, {31'h0, mm_exp_stall});
      chk("rmask", {28'h0, dmem_rmask}, {28'h0, mm_r});
      chk("wmask", {28'h0, dmem_wmask}, {28'h0, mm_w});
      chk("addr", dmem_addr, m_held.alu_out - mm_off);
      if (mm_w != 4'h0) chk("wdata", dmem_wdata, m_held.rs2_v << (8 * mm_off));
      chk("fwd_alu", ex_mem_alu_out_forward, m_held.alu_out);
      chk("fwd_br", {31'h0, ex_mem_br_en_forward}, {31'h0, m_held.br_en});
      chk("fwd_uimm", ex_mem_u_imm_forward, m_held.u_imm);
      chk("fwd_rd", {27'h0, ex_mem_rd_s}, {27'h0, m_held.rd_s});
      chk("fwd_we", {31'h0, ex_mem_regf_we}, {31'h0, m_held.regf_we && m_held.valid});
      chk("wb_valid", {31'h0, mem_wb.valid}, {31'h0, m_wb.valid});
      if (m_wb.valid) begin
        n_checks++;
        if (mem_wb !== m_wb) begin
          n_fail++;
          $display("FAIL wb_record: got %h expected %h at %0t", mem_wb, m_wb, $time);
        end
      end
      // advance to what the next clock edge must produce
      if (!mm_exp_stall) begin
        m_wb.valid          = m_held.valid;
        m_wb.pc             = m_held.pc;
        m_wb.inst           = m_held.inst;
        m_wb.rd_s           = m_held.rd_s;
        m_wb.regf_we        = m_held.regf_we;
        m_wb.regfilemux_sel = m_held.regfilemux_sel;
        m_wb.alu_out        = m_held.alu_out;
        m_wb.br_en          = m_held.br_en;
        m_wb.u_imm          = m_held.u_imm;
        m_wb.dest_phys_new  = m_held.dest_phys_new;
        m_wb.dest_phys_old  = m_held.dest_phys_old;
        m_wb.dest_arch      = m_held.dest_arch;
        m_wb.mem_rdata      = (mm_mem && m_held.opcode == c_OPC_LOAD) ?
                              load_val(m_held.funct3, dmem_rdata, mm_off) : 32'h0;
        m_held       = ex_mem_in;
        m_held.valid = ex_mem_in.valid && !flush;
        m_age        = 0;
      end else begin
        m_wb.valid = 1'b0;
        m_age++;
      end
    end
  end

  // ---------------- stimulus and memory responder ----------------
  ex_mem_stage_reg_t cur_in;
  logic              cur_flush;
  int                force_lat = -1;
  logic [31:0]       force_rdata = 32'h0;
  bit                rand_mode = 1'b0;
  bit                inject_resp = 1'b0;
  bit                pending = 1'b0;
  int                cnt = 0;

  task automatic respond();
    dmem_resp = 1'b1;
    if (force_lat >= 0) dmem_rdata = force_rdata;
  endtask

  task automatic memory();
    int lat;
    dmem_rdata = $urandom;
    if (!rst_n) begin
      pending = 1'b0;
    end else if (!pending && (dmem_rmask | dmem_wmask) != 4'h0) begin
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      if (lat == 0) respond();
      else begin
        pending = 1'b1;
        cnt     = lat;
      end
    end else if (pending) begin
      cnt--;
      if (cnt == 0) begin
        pending = 1'b0;
        respond();
      end
    end else if (inject_resp || (rand_mode && !model_is_mem(m_held) && $urandom_range(0, 7) == 0)) begin
      dmem_resp = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ex_mem_in = cur_in;
    flush     = cur_flush;
    dmem_resp = 1'b0;
    #1;
    memory();
    #1;
  endtask

  function automatic ex_mem_stage_reg_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] rs2);
    ex_mem_stage_reg_t r;
    r = '0;
    r.valid = 1'b1; r.pc = 32'h100; r.inst = 32'hABC; r.opcode = opc; r.funct3 = f3;
    r.rd_s = 5'd5; r.rs2_v = rs2; r.alu_out = alu; r.regf_we = 1'b1; r.dest_arch = 5'd5;
    return r;
  endfunction

  function automatic ex_mem_stage_reg_t rand_inst();
    ex_mem_stage_reg_t r;
    int j;
    r.valid = ($urandom_range(0, 9) != 0);
    r.pc = $urandom; r.inst = $urandom; r.rs2_v = $urandom; r.alu_out = $urandom;
    r.u_imm = $urandom; r.rd_s = 5'($urandom); r.br_en = 1'($urandom);
    r.regf_we = 1'($urandom); r.regfilemux_sel = 4'($urandom);
    r.dest_phys_new = 6'($urandom); r.dest_phys_old = 6'($urandom); r.dest_arch = 5'($urandom);
    r.funct3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: begin
        r.opcode = c_OPC_LOAD;
        j = $urandom_range(0, 4);
        r.funct3 = 3'((j < 3) ? j : j + 1);
      end
      1: begin
        r.opcode = c_OPC_STORE;
        r.funct3 = 3'($urandom_range(0, 2));
      end
      2:       r.opcode = 7'b0110011;
      default: r.opcode = 7'b0110111;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; ex_mem_in = '0; flush = 1'b0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
    cur_in = '0; cur_flush = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // ADD passes straight through
    cur_in = mk(7'b0110011, 3'd0, 32'h1234, 32'h0); step();
    cur_in = '0; step();
    chk("add_stall", {31'h0, stall}, 32'h0);
    step();
    chk("add_wb_valid", {31'h0, mem_wb.valid}, 32'h1);
    chk("add_wb_alu", mem_wb.alu_out, 32'h1234);

    // LB at byte 3 with two-cycle memory
    force_lat = 2; force_rdata = 32'h80FF_FF00;
    cur_in = mk(c_OPC_LOAD, 3'd0, 32'h1003, 32'h0); step();
    cur_in = '0; step();
    chk("lb_rmask", {28'h0, dmem_rmask}, 32'h8);
    chk("lb_addr", dmem_addr, 32'h1000);
    chk("lb_stall0", {31'h0, stall}, 32'h1);
    step();
    chk("lb_stall1", {31'h0, stall}, 32'h1);
    chk("lb_rmask_wait", {28'h0, dmem_rmask}, 32'h0);
    step();
    chk("lb_stall2", {31'h0, stall}, 32'h0);
    step();
    chk("lb_wb_valid", {31'h0, mem_wb.valid}, 32'h1);
    chk("lb_rdata", mem_wb.mem_rdata, 32'hFFFF_FF80);

    // SH to the upper half
    force_lat = 1;
    cur_in = mk(c_OPC_STORE, 3'd1, 32'h2002, 32'h0000_ABCD); step();
    cur_in = '0; step();
    chk("sh_wmask", {28'h0, dmem_wmask}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_0000);
    step();
    chk("sh_wmask_wait", {28'h0, dmem_wmask}, 32'h0);

    // LW then SW against zero-wait memory
    force_lat = 0; force_rdata = 32'h1122_3344;
    cur_in = mk(c_OPC_LOAD, 3'd2, 32'h40, 32'h0); step();
    cur_in = mk(c_OPC_STORE, 3'd2, 32'h44, 32'h5); step();
    chk("lwsw_stall_a", {31'h0, stall}, 32'h0);
    chk("lwsw_rmask", {28'h0, dmem_rmask}, 32'hF);
    cur_in = '0; step();
    chk("lwsw_stall_b", {31'h0, stall}, 32'h0);
    chk("lwsw_wmask", {28'h0, dmem_wmask}, 32'hF);
    chk("lwsw_addr", dmem_addr, 32'h44);
    chk("lwsw_lw_rdata", mem_wb.mem_rdata, 32'h1122_3344);
    step();
    chk("lwsw_sw_wb", {31'h0, mem_wb.valid}, 32'h1);

    // reset while waiting, then a stale response
    force_lat = 100;
    cur_in = mk(c_OPC_LOAD, 3'd2, 32'h80, 32'h0); step();
    cur_in = '0; step(); step();
    chk("rw_stall_wait", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rw_stall_rst", {31'h0, stall}, 32'h0);
    chk("rw_wb_rst", {31'h0, mem_wb.valid}, 32'h0);
    step();
    rst_n = 1'b1; force_lat = -1; inject_resp = 1'b1;
    step();
    inject_resp = 1'b0;
    chk("rw_stall_late", {31'h0, stall}, 32'h0);
    step();
    chk("rw_wb_late", {31'h0, mem_wb.valid}, 32'h0);

    // a fresh load issues at once after reset
    force_lat = 0; force_rdata = 32'hCAFE_0001;
    cur_in = mk(c_OPC_LOAD, 3'd2, 32'h90, 32'h0); step();
    cur_in = '0; step();
    chk("post_rst_rmask", {28'h0, dmem_rmask}, 32'hF);

    // misaligned LW
    cur_in = mk(c_OPC_LOAD, 3'd2, 32'h3001, 32'h0); step();
    cur_in = '0; step();
    chk("mis_rmask", {28'h0, dmem_rmask}, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    step();
    chk("mis_wb_valid", {31'h0, mem_wb.valid}, 32'h1);
    chk("mis_rdata", mem_wb.mem_rdata, 32'h0);

    // randomized traffic
    force_lat = -1; rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cur_in    = rand_inst();
      cur_flush = ($urandom_range(0, 9) == 0);
      step();
      if (i % 1000 == 999) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    cur_in = '0; cur_flush = 1'b0;
    step(); step(); step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; widths fixed (XLEN 32, 5-bit architectural register index).
REQ-002 clk  in  1  single clock, all state rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 ex_mem_in  in  ex_mem_stage_reg_t  execute-stage result.
  - Fields used: valid, pc, inst, opcode, funct3, rd_s, rs2_v, alu_out, br_en, u_imm, regf_we, regfilemux_sel, dest_phys_new, dest_phys_old, dest_arch.
REQ-005 flush  in  1  replace the incoming instruction with a bubble.
REQ-006 dmem_addr  out  32  word-aligned address, {alu_out[31:2],2'b00}.
REQ-007 dmem_rmask  out  4  byte read enables.
REQ-008 dmem_wmask  out  4  byte write enables.
REQ-009 dmem_wdata  out  32  lane-aligned store data.
REQ-010 dmem_rdata  in  32  read data, valid with dmem_resp.
REQ-011 dmem_resp  in  1  one-cycle completion pulse.
REQ-012 stall  out  1  freeze upstream stages and the EX/MEM register.
REQ-013 ex_mem_alu_out_forward  out  32  held alu_out.
REQ-014 ex_mem_br_en_forward  out  1  held br_en.
REQ-015 ex_mem_u_imm_forward  out  32  held u_imm.
REQ-016 ex_mem_rd_s  out  5  held rd_s.
REQ-017 ex_mem_regf_we  out  1  held regf_we AND held valid.
REQ-018 mem_wb  out  mem_wb_stage_reg_t  registered writeback record.
  - Fields: valid, pc, inst, rd_s, regf_we, regfilemux_sel, alu_out, br_en, u_imm, mem_rdata, dest_phys_new, dest_phys_old, dest_arch.

Function
REQ-019 EX/MEM register: loads ex_mem_in when stall=0; loads ex_mem_in with valid forced to 0 when stall=0 and flush=1; holds when stall=1.
REQ-020 flush is ignored while stall=1; the flush source holds flush until stall=0.
REQ-021 mem_op: held valid=1 and opcode is LOAD or STORE, with an aligned access.
REQ-022 Byte offset off = alu_out[1:0].
  - Byte mask: 4'b0001<<off.
  - Half mask: 4'b0011<<off, aligned when off is 0 or 2.
  - Word mask: 4'b1111, aligned when off=0.
REQ-023 Misaligned load or store: no request issued, completes in 1 cycle, mem_rdata=0, no exception.
REQ-024 FSM state IDLE: mem_op=1 drives the request for exactly one cycle and moves to WAIT.
  - Request: rmask for loads or wmask for stores, dmem_addr, and dmem_wdata=rs2_v<<(8*off).
REQ-025 FSM state WAIT: masks=0 and dmem_addr holds; dmem_resp=1 moves to IDLE.
REQ-026 dmem_resp in the IDLE issue cycle is legal (0-wait memory); the FSM stays IDLE and the op completes that cycle.
REQ-027 stall = mem_op AND NOT (dmem_resp in the current cycle).
  - Combinational; a response releases the stall in the same cycle.
REQ-028 Load result selected by funct3 from the shifted dmem_rdata.
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: full word.
REQ-029 mem_wb update on each edge:
  - stall=0: mem_wb loads the held record with mem_rdata; valid copies the held valid.
  - stall=1: mem_wb.valid=0 (bubble); other fields don't-care.
REQ-030 Non-memory valid instructions pass through in 1 cycle with mem_rdata=0.
REQ-031 dmem_resp while IDLE with no outstanding request is ignored.
REQ-032 Back-to-back memory ops: the second request issues the cycle after the first response.

Reset
REQ-033 rst_n low, asynchronously:
  - FSM=IDLE.
  - EX/MEM valid=0 and mem_wb.valid=0; all other register fields 0.
  - Masks 0, stall 0, forwards 0.
REQ-034 Reset during WAIT abandons the outstanding access; a response arriving after reset is ignored per REQ-031.

Verification
REQ-035 ADD, alu_out=0x1234: mem_wb.valid=1 and alu_out=0x1234 one cycle later; stall never 1.
REQ-036 LB, alu_out=0x1003, dmem_rdata=0x80FF_FF00 with resp 2 cycles after issue:
  - Issue cycle: rmask=1000, dmem_addr=0x1000.
  - stall=1 for 2 cycles.
  - mem_rdata=0xFFFFFF80.
REQ-037 SH, alu_out=0x2002, rs2_v=0x0000ABCD: wmask=1100, dmem_wdata=0xABCD0000; mask held only in the issue cycle.
REQ-038 LW then SW back-to-back, 0-wait memory (resp in issue cycle): stall=0 throughout; two requests on consecutive cycles.
REQ-039 rst_n low during WAIT, then a late dmem_resp: FSM=IDLE, no mem_wb.valid produced, stall=0.
REQ-040 LW with alu_out=0x3001 (misaligned): masks 0, no stall, mem_wb.valid=1, mem_rdata=0.
